fifo_tx_serializer: RTL and testbench
=====================================

# fifo_tx_serializer

Downstream drain stage for the 8-bit `fifo`. It pops one byte whenever the FIFO is not empty (`nostock` low) and sends it LSB-first on a single asynchronous-serial line: one start bit, 8 data bits, optional parity, one stop bit. It consumes `fifo.dout` and drives `fifo.rd`. It is the byte-to-wire output of the buffering path.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥2.
- `DATA_W`, 8: data width; must match the FIFO word width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `tx_en`  in  1  enables new frames; a frame in progress always completes.
- `nostock`  in  1  FIFO empty flag.
- `din`  in  DATA_W  FIFO `dout`; valid the cycle after `rd` is high.
- `rd`  out  1  single-cycle FIFO read strobe.
- `txd`  out  1  serial line; idle high.
- `busy`  out  1  high from FETCH through the last STOP cycle.
- `frame_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE: `txd`=1. If `tx_en`=1 and `nostock`=0, go to FETCH.
- FETCH: `rd`=1 for exactly this cycle. Go to LOAD.
- LOAD: capture `din` into the shift register and compute parity. Clear the bit timer and bit index. Go to START.
- START: `txd`=0 for CLKS_PER_BIT cycles.
- DATA: `txd`=shreg[0]. Shift right every CLKS_PER_BIT cycles. After bit index 7, go to PARITY or STOP.
- STOP: `txd`=1 for CLKS_PER_BIT cycles, then go to IDLE. `frame_done` pulses on the IDLE entry cycle.
- `rd` never asserts while `nostock`=1 at the FETCH decision. Never pop from an empty FIFO.
- `tx_en` dropping mid-frame does not abort the frame. It only blocks the next IDLE→FETCH.
- Bit timer: counter of width $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1, which produces a bit tick. The bit index is 3 bits and saturates at DATA_W-1.
- Reset mid-frame: the popped byte is discarded. The FIFO is not rewound.

## Timing
- Reset values: `txd`=1, `rd`=0, `busy`=0, `frame_done`=0, state=IDLE, counters=0.
- Latency from `nostock` falling in IDLE: `rd` high 1 cycle later, `txd` falls 3 cycles later (IDLE→FETCH→LOAD→START).
- Frame length is (10 + P)·CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle, where P=1 with parity and P=0 without.
- Back-to-back frames: 3 idle cycles of `txd`=1 (IDLE, FETCH, LOAD) between a STOP and the next START.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `TX_PARITY_EN` defined: the PARITY state is inserted after DATA. `txd` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. The frame is 11 bits.
- `TX_PARITY_EN` undefined: the PARITY state and its logic are absent. DATA goes directly to STOP. The frame is 10 bits.

## Structure
- Shared package `tx_ser_pkg`:
  - state encoding typedef;
  - `IDLE_LEVEL`=1, `START_LEVEL`=0, `STOP_LEVEL`=1;
  - `FRAME_BITS` constant (10, or 11 under the macro).
- One sub-module, `bit_timer`: a parameterised CLKS_PER_BIT counter with a synchronous clear input and a `tick` output.

## Test plan
- Reset held low mid-DATA with `txd`=0 → `txd`=1, `rd`=0, `busy`=0 immediately. After release, a fresh frame starts only on `nostock`=0.
- CLKS_PER_BIT=4, FIFO holds 8'hA5, no parity:
  - `txd` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total);
  - `frame_done` pulses once;
  - exactly one `rd` pulse.
- Same stimulus with `TX_PARITY_EN` → parity bit 0 inserted before stop; 44-cycle frame. With 8'h01 → parity bit 1.
- FIFO loaded with 3 bytes (11,22,33) → three frames in order, 3 idle cycles between them, 3 `rd` pulses. The FIFO reaches `nostock`=1 and no further `rd` occurs.
- `tx_en` dropped during the DATA of byte 1 of 2 → byte 1 completes; byte 2 is not fetched until `tx_en` returns high.
- `nostock`=1 for 100 cycles → `rd` stays 0, `txd` stays 1, `busy` stays 0.

Source files
------------

// File: rtl/tx_ser_pkg.sv
// Shared types and line levels for the FIFO-draining async-serial transmitter.
// Build option: define TX_PARITY_EN to insert an even-parity bit after the data bits.
package tx_ser_pkg;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } tx_state_e;
  localparam int unsigned FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
  } tx_state_e;
  localparam int unsigned FRAME_BITS = 10;
`endif

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// Free-running bit-period counter: wraps every CLKS_PER_BIT cycles and flags the wrap as a tick.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned     CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops bytes from the upstream FIFO and sends them LSB-first as start/data/[parity]/stop frames.
// Build option: TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module fifo_tx_serializer
  import tx_ser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              nostock,
  input  logic [DATA_W-1:0] din,
  output logic              rd,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned   IW       = $clog2(DATA_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IW-1:0]     idx_q;
  logic              txd_q, rd_q, busy_q, done_q;
`ifdef TX_PARITY_EN
  logic              par_q;
`endif

  logic tmr_clr, tick, shift_en;

  // The timer only runs while bits are on the wire, so START always begins at count 0.
  assign tmr_clr  = (state_q == S_IDLE) || (state_q == S_FETCH) || (state_q == S_LOAD);
  assign shift_en = (state_q == S_DATA) && tick && (idx_q != IDX_LAST);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      txd_q   <= IDLE_LEVEL;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          txd_q <= IDLE_LEVEL;
          if (tx_en && !nostock) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          idx_q   <= '0;
          txd_q   <= START_LEVEL;
          state_q <= S_START;
        end
        S_START: begin
          if (tick) begin
            txd_q   <= shreg_q[0];
            state_q <= S_DATA;
          end
        end
        // The next bit is presented from shreg_q[1] because the shift lands on the same edge.
        S_DATA: begin
          if (tick) begin
            if (idx_q == IDX_LAST) begin
`ifdef TX_PARITY_EN
              txd_q   <= par_q;
              state_q <= S_PARITY;
`else
              txd_q   <= STOP_LEVEL;
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
              txd_q <= shreg_q[1];
            end
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            txd_q   <= STOP_LEVEL;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            txd_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Payload registers carry no reset; a byte caught by reset is simply dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      shreg_q <= din;
`ifdef TX_PARITY_EN
      par_q   <= ^din;
`endif
    end else if (shift_en) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  assign rd         = rd_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed/randomized bench for fifo_tx_serializer with a simple FIFO model and wire-level frame checker.
module tb_fifo_tx_serializer;

  localparam int CPB = 4;
`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       nostock;
  logic [7:0] din;
  logic       rd, txd, busy, frame_done;

  int total = 0;
  int bad   = 0;

  // FIFO model: the initial block owns wr_ptr/mem, the pop process owns rd_ptr/din/nostock.
  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int underflow = 0;

  always #5 clk = ~clk;

  fifo_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .nostock    (nostock),
    .din        (din),
    .rd         (rd),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (rd === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      if (rd_ptr == wr_ptr) underflow = underflow + 1;
      else begin
        din    = mem[rd_ptr % 64];
        rd_ptr = rd_ptr + 1;
      end
    end
    nostock = (rd_ptr == wr_ptr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) mem[(wr_ptr + i) % 64] = bs[i];
    wr_ptr = wr_ptr + n;
    @(negedge clk);
  endtask

  task automatic wait_start(output int n, output logic found);
    n = 0;
    found = 1'b0;
    while (n < 200 && !found) begin
      @(negedge clk);
      n++;
      if (txd === 1'b0) found = 1'b1;
    end
  endtask

  // Checks one whole frame on the wire, cycle by cycle, from the first START cycle to IDLE entry.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int exp_gap, input int drop_at);
    int   n, errs, busy_errs, nb;
    logic found;
    logic lv [11];
    errs = 0; busy_errs = 0;
    nb = 10 + PB;
    wait_start(n, found);
    chk({tag, "_start_seen"}, found, 1'b1);
    if (!found) return;
    if (exp_gap >= 0) chk({tag, "_gap"}, n, exp_gap);
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i + 1] = b[i];
`ifdef TX_PARITY_EN
    lv[9] = ^b;
`endif
    lv[nb - 1] = 1'b1;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (k * CPB + c == drop_at) tx_en = 1'b0;
        if (txd !== lv[k]) errs++;
        if (busy !== 1'b1 || frame_done !== 1'b0) busy_errs++;
      end
    end
    chk({tag, "_bits"}, errs, 0);
    chk({tag, "_busy"}, busy_errs, 0);
    @(negedge clk);
    chk({tag, "_done"}, frame_done, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_txd_idle"}, txd, 1'b1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int q;
    q = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rd !== 1'b0 || txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) q++;
    end
    chk(tag, q, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         n;
    logic       found;
    logic [7:0] r [4];

    rst   = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_rd", rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);

    rst   = 1'b1;
    tx_en = 1'b1;
    quiet("empty_quiet", 100);
    chk("empty_rd_cnt", rd_cnt, 0);

    base = rd_cnt;
    push_bytes(1, 8'hA5, 8'h00, 8'h00, 8'h00);
    expect_frame("a5", 8'hA5, 3, -1);
    chk("a5_rd_pulses", rd_cnt - base, 1);

    push_bytes(1, 8'h01, 8'h00, 8'h00, 8'h00);
    expect_frame("x01", 8'h01, 3, -1);

    base = rd_cnt;
    push_bytes(3, 8'h11, 8'h22, 8'h33, 8'h00);
    expect_frame("b11", 8'h11, 3, -1);
    expect_frame("b22", 8'h22, 3, -1);
    expect_frame("b33", 8'h33, 3, -1);
    quiet("drained_quiet", 20);
    chk("three_rd_pulses", rd_cnt - base, 3);
    chk("drained_nostock", nostock, 1'b1);

    for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, 255));
    base = rd_cnt;
    push_bytes(2, r[0], r[1], 8'h00, 8'h00);
    expect_frame("en_b1", r[0], 3, 3 * CPB);
    quiet("en_low_quiet", 30);
    chk("en_low_rd_pulses", rd_cnt - base, 1);
    tx_en = 1'b1;
    expect_frame("en_b2", r[1], 3, -1);

    for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, 255));
    push_bytes(4, r[0], r[1], r[2], r[3]);
    for (int i = 0; i < 4; i++) expect_frame($sformatf("rnd%0d", i), r[i], (i == 0) ? -1 : 3, -1);

    base = rd_cnt;
    push_bytes(1, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_start(n, found);
    chk("rst_mid_start_seen", found, 1'b1);
    repeat (CPB + 2) @(negedge clk);
    chk("pre_rst_txd", txd, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_rd", rd, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    quiet("post_rst_quiet", 20);
    chk("post_rst_rd_pulses", rd_cnt - base, 1);
    push_bytes(1, 8'h3C, 8'h00, 8'h00, 8'h00);
    expect_frame("after_rst", 8'h3C, 3, -1);

    chk("no_underflow", underflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
